// File: rtl/imm_encoder_if.sv
// Request/response stream bundle for the immediate encoder.
// master drives requests and out_ready; slave is the encoder itself.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_kind, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_last
  );

  modport slave (
    input  in_valid, in_kind, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_err, out_last
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs an immediate plus register/opcode fields into an RV32 instruction
// word, range-checking the immediate. LI expands into LUI+ADDI when both
// halves are non-zero, emitted as two beats on the output stream.
module imm_encoder (
  input logic          clk,
  input logic          rst_n,
  imm_encoder_if.slave bus
);

  localparam logic [2:0] KIND_I  = 3'b000;
  localparam logic [2:0] KIND_S  = 3'b001;
  localparam logic [2:0] KIND_B  = 3'b010;
  localparam logic [2:0] KIND_J  = 3'b011;
  localparam logic [2:0] KIND_U  = 3'b100;
  localparam logic [2:0] KIND_LI = 3'b101;

  typedef enum logic {ONE, TWO} state_t;

  state_t      state;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic        out_err_q;
  logic        out_last_q;
  logic [31:0] pend_instr;

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  op;

  logic        fits12;
  logic        fits13;
  logic        fits20;
  logic        fits21;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] li_lui;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        enc_last;
  logic        enc_two;
  logic [31:0] enc_second;
  logic        accept;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign op  = bus.in_opcode;

  // An immediate fits N bits signed when every bit above the sign bit copies it.
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits20 = (imm[31:19] == {13{imm[19]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  // Adding 0x800 before taking bits [31:12] carries into the upper field
  // exactly when imm[11] is set, which compensates ADDI's sign extension.
  assign li_hi  = imm[31:12] + {19'd0, imm[11]};
  assign li_lo  = imm[11:0];
  assign li_lui = {li_hi, rd, 7'h37};

  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.in_ready = (state == ONE) && (!out_valid_q || bus.out_ready);

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_last  = out_last_q;

  // Encode the presented request into its first beat and, for a split LI, the held second beat.
  always_comb begin
    enc_instr  = 32'd0;
    enc_err    = 1'b0;
    enc_last   = 1'b1;
    enc_two    = 1'b0;
    enc_second = 32'd0;
    case (bus.in_kind)
      KIND_I: begin
        if (fits12) enc_instr = {imm[11:0], rs1, f3, rd, op};
        else        enc_err   = 1'b1;
      end
      KIND_S: begin
        if (fits12) enc_instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        else        enc_err   = 1'b1;
      end
      KIND_B: begin
        if (fits13 && !imm[0]) enc_instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        else                   enc_err   = 1'b1;
      end
      KIND_J: begin
        if (fits21 && !imm[0]) enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        else                   enc_err   = 1'b1;
      end
      KIND_U: begin
        if (fits20) enc_instr = {imm[19:0], rd, op};
        else        enc_err   = 1'b1;
      end
      KIND_LI: begin
        if (li_hi == 20'd0) begin
          enc_instr = {li_lo, 5'd0, 3'b000, rd, 7'h13};
        end else if (li_lo == 12'd0) begin
          enc_instr = li_lui;
        end else begin
          enc_instr  = li_lui;
          enc_last   = 1'b0;
          enc_two    = 1'b1;
          enc_second = {li_lo, rd, 3'b000, rd, 7'h13};
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Output register and beat sequencing: load on accept, swap in the held ADDI once the LUI drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ONE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      pend_instr  <= 32'd0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_instr_q <= enc_instr;
      out_err_q   <= enc_err;
      out_last_q  <= enc_last;
      pend_instr  <= enc_second;
      state       <= enc_two ? TWO : ONE;
    end else if (state == TWO && bus.out_ready) begin
      out_instr_q <= pend_instr;
      out_last_q  <= 1'b1;
      state       <= ONE;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodings, backpressure,
// back-to-back throughput, reset during LI and randomized traffic against
// an arithmetic reference model.
module tb_imm_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_encoder_if bus();

  imm_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
    int          cyc;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  beat_t got_q[$];
  beat_t exp_q[$];

  // Free-running cycle count used to measure latency and throughput.
  always @(posedge clk) cyc++;

  // Record every beat the downstream accepts (sampled mid-cycle, consumed at the next rising edge).
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      got_q.push_back('{bus.out_instr, bus.out_err, bus.out_last, cyc});
  end

  function automatic req_t mk(input logic [2:0] kind, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    req_t r;
    r.kind = kind; r.op = op; r.f3 = f3; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  // Reference model: range checks on the signed value, fields placed by shift-and-mask.
  function automatic void model(input req_t r);
    int          si;
    logic [31:0] w;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    logic        ok;
    si = $signed(r.imm);
    rd = 32'(r.rd);
    w  = 32'd0;
    ok = 1'b1;
    case (r.kind)
      3'd0: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = ((r.imm & 32'hfff) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (rd << 7) | 32'(r.op);
      end
      3'd1: begin
        ok = (si >= -2048) && (si <= 2047);
        w  = (((r.imm >> 5) & 32'h7f) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) |
             (32'(r.f3) << 12) | ((r.imm & 32'h1f) << 7) | 32'(r.op);
      end
      3'd2: begin
        ok = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
        w  = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3f) << 25) | (32'(r.rs2) << 20) |
             (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (((r.imm >> 1) & 32'hf) << 8) |
             (((r.imm >> 11) & 32'h1) << 7) | 32'(r.op);
      end
      3'd3: begin
        ok = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
        w  = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3ff) << 21) |
             (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hff) << 12) | (rd << 7) | 32'(r.op);
      end
      3'd4: begin
        ok = (si >= -524288) && (si <= 524287);
        w  = ((r.imm & 32'hfffff) << 12) | (rd << 7) | 32'(r.op);
      end
      3'd5: begin
        hi = (r.imm + 32'h800) >> 12;
        lo = r.imm & 32'hfff;
        if (hi == 0) begin
          exp_q.push_back('{(lo << 20) | (rd << 7) | 32'h13, 1'b0, 1'b1, 0});
        end else if (lo == 0) begin
          exp_q.push_back('{(hi << 12) | (rd << 7) | 32'h37, 1'b0, 1'b1, 0});
        end else begin
          exp_q.push_back('{(hi << 12) | (rd << 7) | 32'h37, 1'b0, 1'b0, 0});
          exp_q.push_back('{(lo << 20) | (rd << 15) | (rd << 7) | 32'h13, 1'b0, 1'b1, 0});
        end
        return;
      end
      default: ok = 1'b0;
    endcase
    if (ok) exp_q.push_back('{w, 1'b0, 1'b1, 0});
    else    exp_q.push_back('{32'd0, 1'b1, 1'b1, 0});
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = $urandom_range(0, 8191) - 4096;
      2: v = $urandom_range(0, 4194303) - 2097152;
      3: begin
        case ($urandom_range(0, 11))
          0:  v = 32'h000007ff;
          1:  v = 32'h00000800;
          2:  v = 32'hfffff800;
          3:  v = 32'hfffff7ff;
          4:  v = 32'h00001000;
          5:  v = 32'h0007ffff;
          6:  v = 32'h00080000;
          7:  v = 32'hfff80000;
          8:  v = 32'h000fffff;
          9:  v = 32'h00100000;
          10: v = 32'hfff00000;
          default: v = 32'h7ffff800;
        endcase
        v = v + $urandom_range(0, 2) - 1;
      end
      default: v = ($urandom_range(0, 65535) - 32768) & 32'hfffffffe;
    endcase
    return v;
  endfunction

  // Present one request at posedge+1 and hold it until accepted; optional random out_ready.
  task automatic send(input req_t r, input bit rnd, output int acc);
    logic ok;
    bus.in_valid  = 1'b1;
    bus.in_kind   = r.kind;
    bus.in_opcode = r.op;
    bus.in_funct3 = r.f3;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_imm    = r.imm;
    if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc = cyc;
        break;
      end
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("[TB] FAIL accept_timeout: request kind=%0d never accepted within 200 cycles", r.kind);
    end
  endtask

  task automatic wait_drain(input int base, input int n);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (got_q.size() - base >= n) break;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() - base != n) begin
      errors++;
      $display("[TB] FAIL beat_count: got %0d beats, expected %0d", got_q.size() - base, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_kind   = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_funct3 = 3'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_imm    = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b i=%h e=%b l=%b rdy=%b, expected v=0 i=0 e=0 l=0 rdy=1",
               bus.out_valid, bus.out_instr, bus.out_err, bus.out_last, bus.in_ready);
    end
  endtask

  task automatic test_encodings();
    req_t        r;
    int          nb;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        e0;
    logic        l0;
    int          acc;
    int          base;
    for (int v = 0; v < 13; v++) begin
      nb = 1; i1 = 32'd0; e0 = 1'b0; l0 = 1'b1;
      case (v)
        0:  begin r = mk(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hffffffff); i0 = 32'hfff00093; end
        1:  begin r = mk(3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hfffffffc); i0 = 32'hfe20ae23; end
        2:  begin r = mk(3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'h00000800); i0 = 32'd0; e0 = 1'b1; end
        3:  begin r = mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd8);        i0 = 32'h00000463; end
        4:  begin r = mk(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd7);        i0 = 32'd0; e0 = 1'b1; end
        5:  begin r = mk(3'd3, 7'h6f, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800); i0 = 32'h001000ef; end
        6:  begin r = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345fff);
                  nb = 2; i0 = 32'h123462b7; l0 = 1'b0; i1 = 32'hfff28293; end
        7:  begin r = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h000007ff); i0 = 32'h7ff00293; end
        8:  begin r = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00001000); i0 = 32'h000012b7; end
        9:  begin r = mk(3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0);        i0 = 32'd0; e0 = 1'b1; end
        10: begin r = mk(3'd4, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00080000); i0 = 32'd0; e0 = 1'b1; end
        11: begin r = mk(3'd4, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'hfff80000); i0 = 32'h800000b7; end
        default: begin r = mk(3'd3, 7'h6f, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000); i0 = 32'd0; e0 = 1'b1; end
      endcase
      base = got_q.size();
      send(r, 1'b0, acc);
      wait_drain(base, nb);
      if (got_q.size() - base >= 1) begin
        checks++;
        if (got_q[base].instr !== i0 || got_q[base].err !== e0 || got_q[base].last !== l0) begin
          errors++;
          $display("[TB] FAIL enc_vec%0d_beat0: got i=%h e=%b l=%b, expected i=%h e=%b l=%b",
                   v, got_q[base].instr, got_q[base].err, got_q[base].last, i0, e0, l0);
        end
        checks++;
        if (got_q[base].cyc !== acc) begin
          errors++;
          $display("[TB] FAIL enc_vec%0d_latency: output at cycle %0d, expected cycle %0d",
                   v, got_q[base].cyc, acc);
        end
      end
      if (nb == 2 && got_q.size() - base >= 2) begin
        checks++;
        if (got_q[base+1].instr !== i1 || got_q[base+1].err !== 1'b0 || got_q[base+1].last !== 1'b1) begin
          errors++;
          $display("[TB] FAIL enc_vec%0d_beat1: got i=%h e=%b l=%b, expected i=%h e=0 l=1",
                   v, got_q[base+1].instr, got_q[base+1].err, got_q[base+1].last, i1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int base;
    int ebase;
    req_t r;
    r = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345fff);
    bus.out_ready = 1'b0;
    base  = got_q.size();
    ebase = exp_q.size();
    model(r);
    send(r, 1'b0, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h123462b7 || bus.out_last !== 1'b0 ||
          bus.out_err !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got v=%b i=%h l=%b e=%b rdy=%b, expected v=1 i=123462b7 l=0 e=0 rdy=0",
                 k, bus.out_valid, bus.out_instr, bus.out_last, bus.out_err, bus.in_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lui_drain_in_ready: got %b, expected 0", bus.in_ready);
    end
    wait_drain(base, 2);
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() - base > i) begin
        checks++;
        if (got_q[base+i].instr !== exp_q[ebase+i].instr || got_q[base+i].last !== exp_q[ebase+i].last ||
            got_q[base+i].err !== exp_q[ebase+i].err) begin
          errors++;
          $display("[TB] FAIL stall_beat%0d: got i=%h l=%b e=%b, expected i=%h l=%b e=%b", i,
                   got_q[base+i].instr, got_q[base+i].last, got_q[base+i].err,
                   exp_q[ebase+i].instr, exp_q[ebase+i].last, exp_q[ebase+i].err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   acc[8];
    int   base;
    int   ebase;
    req_t r;
    bus.out_ready = 1'b1;
    base  = got_q.size();
    ebase = exp_q.size();
    for (int i = 0; i < 8; i++) begin
      r = mk(3'd0, 7'h13, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'd0, $urandom_range(0, 4095) - 2048);
      model(r);
      send(r, 1'b0, acc[i]);
    end
    wait_drain(base, 8);
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (acc[i] != acc[0] + i) begin
        errors++;
        $display("[TB] FAIL b2b_accept%0d: accepted at cycle %0d, expected %0d", i, acc[i], acc[0] + i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (got_q.size() - base > i) begin
        checks++;
        if (got_q[base+i].instr !== exp_q[ebase+i].instr || got_q[base+i].err !== 1'b0 ||
            got_q[base+i].cyc !== acc[0] + i) begin
          errors++;
          $display("[TB] FAIL b2b_beat%0d: got i=%h e=%b cyc=%0d, expected i=%h e=0 cyc=%0d", i,
                   got_q[base+i].instr, got_q[base+i].err, got_q[base+i].cyc, exp_q[ebase+i].instr, acc[0] + i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_li();
    int   acc;
    int   base;
    req_t r;
    r = mk(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345fff);
    bus.out_ready = 1'b0;
    base = got_q.size();
    send(r, 1'b0, acc);
    #2;
    checks++;
    if (bus.out_instr !== 32'h123462b7 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_lui_present: got v=%b i=%h, expected v=1 i=123462b7", bus.out_valid, bus.out_instr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got v=%b i=%h e=%b l=%b rdy=%b, expected v=0 i=0 e=0 l=0 rdy=1",
               bus.out_valid, bus.out_instr, bus.out_err, bus.out_last, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != base || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_no_addi: got %0d beats v=%b, expected 0 beats v=0", got_q.size() - base, bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_in_ready: got %b, expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int   acc;
    int   base;
    int   ebase;
    int   n;
    req_t r;
    base  = got_q.size();
    ebase = exp_q.size();
    for (int i = 0; i < 300; i++) begin
      r = mk(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rand_imm());
      model(r);
      send(r, 1'b1, acc);
    end
    bus.out_ready = 1'b1;
    n = exp_q.size() - ebase;
    wait_drain(base, n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() - base > i) begin
        checks++;
        if (got_q[base+i].instr !== exp_q[ebase+i].instr || got_q[base+i].err !== exp_q[ebase+i].err ||
            got_q[base+i].last !== exp_q[ebase+i].last) begin
          errors++;
          $display("[TB] FAIL rand_beat%0d: got i=%h e=%b l=%b, expected i=%h e=%b l=%b", i,
                   got_q[base+i].instr, got_q[base+i].err, got_q[base+i].last,
                   exp_q[ebase+i].instr, exp_q[ebase+i].err, exp_q[ebase+i].last);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_li();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Packs an immediate plus register/opcode fields into a 32-bit RV32 instruction word. This is the inverse of the immediate extender, and round-trips through it for the I, B, J and U formats. It sits in the test/boot instruction generator, ahead of instruction memory writes. It range-checks every immediate and expands the load-immediate pseudo-op (LI) into a two-beat LUI+ADDI sequence over a valid/ready stream.

## Interface
No parameters.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_kind  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI; 110/111 illegal
- in_opcode  in  7  opcode field; ignored for LI
- in_funct3  in  3  funct3 field; ignored for J, U, LI
- in_rd, in_rs1, in_rs2  in  5 each  register fields; unused fields ignored
- in_imm  in  32  immediate value
- out_valid  out  1  instruction word valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate not representable or kind illegal; out_instr = 0 when set
- out_last  out  1  final beat of the request

## Operation
- I: imm must equal sign-extension of imm[11:0]; out_instr = {imm[11:0], rs1, funct3, rd, opcode}.
- S: imm must equal sign-extension of imm[11:0]; out_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- B: imm[0]=0 and imm equals sign-extension of imm[12:0]; out_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- J: imm[0]=0 and imm equals sign-extension of imm[20:0]; out_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- U: in_imm is the right-aligned 20-bit field, the same form the extender's U output produces. It must equal sign-extension of imm[19:0]; out_instr = {imm[19:0], rd, opcode}.
- LI: hi = (imm + 32'h800) >> 12, taking bits [31:12] of the 32-bit wrapped sum; lo = imm[11:0].
  - hi≠0 and lo≠0: beat 1 LUI {hi, rd, 7'h37}, last=0; beat 2 ADDI {lo, rd, 3'b000, rd, 7'h13}, last=1.
  - hi=0: single ADDI {lo, 5'd0, 3'b000, rd, 7'h13}.
  - lo=0, hi≠0: single LUI.
  - LI never errors.
- Error (range fail, misaligned B/J, illegal kind): single beat with out_instr=0, out_err=1, out_last=1.
- States:
  - ONE: output register empty, or holding a single or final beat.
  - TWO: output holds the LUI, and the ADDI is pending in a held register.
- ONE→TWO: an accepted LI needs two beats.
- TWO→ONE: the LUI is consumed; the ADDI loads into the output register in the same cycle.

## Timing
- Reset: out_valid=0, out_instr=0, out_err=0, out_last=0, state ONE; in_ready=1 while rst_n low or right after.
- in_ready = (state==ONE) && (!out_valid || out_ready), combinational. Accept and drain can occur in the same cycle.
- Latency is 1 cycle: a request accepted at edge N drives out_valid high after edge N.
- Throughput is 1 instruction/cycle for non-LI requests. An LI request holds in_ready low for the cycle its LUI is on the output.
- While out_valid && !out_ready, out_instr, out_err and out_last are held stable.
- Reset asserted mid-LI discards the pending ADDI; no beat is emitted after rst_n rises.
- All arithmetic is 32-bit modulo; inputs are not registered beyond acceptance.

## Test plan
- I, rd=1, rs1=0, opcode 0x13, imm 0xFFFFFFFF → 0xFFF00093, err=0, last=1, one cycle after accept.
- S, opcode 0x23, funct3 2, rs1=1, rs2=2, imm 0xFFFFFFFC → 0xFE20AE23. S imm 0x800 → out_instr 0, err=1.
- B, opcode 0x63, imm 8 → 0x00000463. Same with imm 7 → err=1. J, opcode 0x6F, rd=1, imm 0x800 → 0x001000EF.
- LI rd=5, imm 0x12345FFF → 0x123462B7 (last=0), then 0xFFF28293 (last=1). LI imm 0x7FF → single 0x7FF00293. LI imm 0x1000 → single 0x000012B7.
- Backpressure: hold out_ready=0 for 3 cycles mid-LI → out_instr stable, in_ready=0 throughout, no beat lost or duplicated. Back-to-back I requests with out_ready=1 → one word per cycle.
- Assert rst_n=0 while the LUI is on the output → outputs go to reset values immediately, the ADDI is never emitted, and in_ready=1 after release.
